// File: rtl/miriscv_bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_bpu_pkg
// Description : Shared types and helpers for the miriscv branch prediction
//               unit: predictor mode enum, counter reset value and the
//               saturating counter step function.
// Revision    : 1.0 - initial release
// ============================================================================
package miriscv_bpu_pkg;

  // Conditional-branch prediction schemes.
  typedef enum logic [1:0] {
    BPU_STATIC  = 2'd0,
    BPU_BIMODAL = 2'd1,
    BPU_GSHARE  = 2'd2
  } bpu_mode_e;

  // Widest counter the helpers are written for.
  localparam int unsigned CNT_W_MAX = 4;

  // Weakly-not-taken value for a counter of the given width:
  // 2^(w-1)-1, which is 0 for a one-bit counter.
  function automatic logic [CNT_W_MAX-1:0] cnt_rst_val(input int unsigned cnt_w);
    return CNT_W_MAX'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Saturating up/down step of a cnt_w-bit counter held in the low bits.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat_next(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic                 taken,
    input int unsigned          cnt_w
  );
    logic [CNT_W_MAX:0] max_val;
    max_val = (5'd1 << cnt_w) - 5'd1;
    if (taken) begin
      return ({1'b0, cnt} >= max_val) ? cnt : cnt + 4'd1;
    end
    return (cnt == '0) ? cnt : cnt - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_bpu_if.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_bpu_if
// Description : Decode lookup / execute training bus of the branch predictor.
//               The master side is the pipeline, the slave side is the BPU.
// Revision    : 1.0 - initial release
// ============================================================================
interface miriscv_bpu_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
);
  // decode-stage lookup
  logic             d_valid_i;
  logic [XLEN-1:0]  d_pc_i;
  logic             d_branch_i;
  logic             d_jal_i;
  logic             d_jalr_i;
  logic             d_imm_sign_i;
  logic [XLEN-1:0]  d_target_i;
  logic             d_taken_o;
  logic [XLEN-1:0]  d_target_o;
  logic [IDX_W-1:0] d_index_o;
  // execute-stage training
  logic             e_update_i;
  logic [IDX_W-1:0] e_index_i;
  logic             e_taken_i;
  logic             cu_kill_i;

  modport master (
    output d_valid_i, d_pc_i, d_branch_i, d_jal_i, d_jalr_i, d_imm_sign_i,
           d_target_i, e_update_i, e_index_i, e_taken_i, cu_kill_i,
    input  d_taken_o, d_target_o, d_index_o
  );

  modport slave (
    input  d_valid_i, d_pc_i, d_branch_i, d_jal_i, d_jalr_i, d_imm_sign_i,
           d_target_i, e_update_i, e_index_i, e_taken_i, cu_kill_i,
    output d_taken_o, d_target_o, d_index_o
  );
endinterface
`default_nettype wire

// File: rtl/miriscv_bpu_cnt_table.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_bpu_cnt_table
// Description : DEPTH x CNT_W saturating counter array. One combinational
//               read port, one synchronous saturating write port; the read
//               port shows the pre-write value in the cycle of a write.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_bpu_cnt_table
  import miriscv_bpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk_i,
  input  wire logic             arstn_i,
  input  wire logic [IDX_W-1:0] rd_idx_i,
  output logic      [CNT_W-1:0] rd_cnt_o,
  input  wire logic             wr_en_i,
  input  wire logic [IDX_W-1:0] wr_idx_i,
  input  wire logic             wr_taken_i
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_rst_val(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] wr_next;

  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign wr_next  = CNT_W'(cnt_sat_next(CNT_W_MAX'(cnt_q[wr_idx_i]), wr_taken_i, CNT_W));

  // Counter storage: async clear to weakly-not-taken, train one entry per edge.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= RST_VAL;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/miriscv_bpu.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_bpu
// Description : Decode-stage branch prediction unit. Jumps are always taken;
//               conditional branches use static BTFN, bimodal or gshare
//               prediction. Counters are trained from execute resolution
//               using the index that travelled with the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_bpu
  import miriscv_bpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MODE      = 1,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int GHR_W     = 6,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  wire logic   clk_i,
  input  wire logic   arstn_i,
  miriscv_bpu_if.slave bpu
);

  localparam bpu_mode_e MODE_E = bpu_mode_e'(MODE);

  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             cnt_msb;
  logic             upd_en;
  logic             unused_sink;

  assign pc_idx = bpu.d_pc_i[IDX_W+1:2];
  // A flush in the same cycle drops the training pulse entirely.
  assign upd_en = bpu.e_update_i & ~bpu.cu_kill_i;

  if (MODE_E == BPU_GSHARE) begin : g_ghr
    logic [GHR_W-1:0] ghr;

    // Non-speculative global history: shifts only on resolved branches.
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        ghr <= '0;
      end else if (upd_en) begin
        ghr <= GHR_W'({ghr, bpu.e_taken_i});
      end
    end

    assign lookup_idx = pc_idx ^ IDX_W'(ghr);
  end else begin : g_no_ghr
    assign lookup_idx = pc_idx;
  end

  if (MODE_E != BPU_STATIC) begin : g_bht
    logic [CNT_W-1:0] rd_cnt;

    miriscv_bpu_cnt_table #(
      .DEPTH (BHT_DEPTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
    ) u_cnt_table (
      .clk_i      (clk_i),
      .arstn_i    (arstn_i),
      .rd_idx_i   (lookup_idx),
      .rd_cnt_o   (rd_cnt),
      .wr_en_i    (upd_en),
      .wr_idx_i   (bpu.e_index_i),
      .wr_taken_i (bpu.e_taken_i)
    );

    assign cnt_msb = rd_cnt[CNT_W-1];
  end else begin : g_no_bht
    assign cnt_msb = 1'b0;
  end

  // Direction decision; forced not-taken while in reset or with no instruction.
  always_comb begin
    bpu.d_taken_o = 1'b0;
    if (arstn_i && bpu.d_valid_i) begin
      if (bpu.d_jal_i || bpu.d_jalr_i) begin
        bpu.d_taken_o = 1'b1;
      end else if (bpu.d_branch_i) begin
        bpu.d_taken_o = (MODE_E == BPU_STATIC) ? bpu.d_imm_sign_i : cnt_msb;
      end
    end
  end

  assign bpu.d_target_o = bpu.d_target_i;
  assign bpu.d_index_o  = lookup_idx;

  // Inputs that only some modes consume, and PC bits outside the index.
  assign unused_sink = ^{bpu.d_pc_i, bpu.d_imm_sign_i, bpu.e_index_i,
                         bpu.e_taken_i, upd_en};

endmodule
`default_nettype wire
